// File: rtl/led_trail_pwm.sv
// led_trail_pwm: turns the scanner's raw LED pattern into PWM-driven LED pins.
// A lit LED jumps to full brightness, then fades geometrically once released,
// leaving a comet trail behind the scanner head. One PWM counter is shared
// by all channels.
module led_trail_pwm #(
  parameter int N_LEDS      = 8,
  parameter int PWM_BITS    = 8,
  parameter int DECAY_DIV   = 2000000,
  parameter int DECAY_SHIFT = 1
) (
  input  logic              clki,
  input  logic              reset,
  input  logic              en,
  input  logic [N_LEDS-1:0] leds_in,
  output logic [N_LEDS-1:0] leds_out,
  output logic              pwm_wrap
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  // A one-cycle decay period still needs a 1-bit counter to stay legal.
  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_DIV - 1);

  logic [N_LEDS-1:0]   leds_q_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [DW-1:0]       decay_cnt_reg;
  logic [N_LEDS-1:0]   leds_out_reg;
  logic                pwm_wrap_reg;
  logic [N_LEDS-1:0]   pwm_on;
  logic                decay_tick;

  assign decay_tick = (decay_cnt_reg == DECAY_LAST);

  // Register the scanner pattern; same clock, so no synchroniser is needed.
  always_ff @(posedge clki) begin
    if (reset) leds_q_reg <= '0;
    else       leds_q_reg <= leds_in;
  end

  // Decay timer: one tick every DECAY_DIV cycles.
  always_ff @(posedge clki) begin
    if (reset)           decay_cnt_reg <= '0;
    else if (decay_tick) decay_cnt_reg <= '0;
    else                 decay_cnt_reg <= decay_cnt_reg + DW'(1);
  end

  // Free-running PWM counter; wraps MAX -> 0 by natural overflow.
  always_ff @(posedge clki) begin
    if (reset) pwm_cnt_reg <= '0;
    else       pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
  end

  // Per-channel brightness: a hit beats a decay tick, and shifting to zero is terminal.
  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_chan
    logic [PWM_BITS-1:0] bright_reg;

    // Brightness register with hit > decay > hold priority.
    always_ff @(posedge clki) begin
      if (reset)               bright_reg <= '0;
      else if (leds_q_reg[gi]) bright_reg <= MAX;
      else if (decay_tick)     bright_reg <= bright_reg >> DECAY_SHIFT;
    end

    // MAX brightness still leaves one dark slot per period; that is intended.
    assign pwm_on[gi] = (pwm_cnt_reg < bright_reg);
  end

  // Registered LED drive, blanked by en without disturbing the fade state.
  always_ff @(posedge clki) begin
    if (reset) leds_out_reg <= '0;
    else       leds_out_reg <= en ? pwm_on : '0;
  end

  // Wrap strobe lines up with the cycle in which the counter reads zero.
  always_ff @(posedge clki) begin
    if (reset) pwm_wrap_reg <= 1'b0;
    else       pwm_wrap_reg <= (pwm_cnt_reg == MAX);
  end

  assign leds_out = leds_out_reg;
  assign pwm_wrap = pwm_wrap_reg;

endmodule
